// File: rtl/risc_v_mike_mmio_uart.sv
// risc_v_mike_mmio_uart
//   Memory-mapped UART responder sitting at the MMIO end of the core data bus.
//   Decodes a 4-word register window, buffers TX bytes in a small FIFO and
//   serialises them as 8N1, and deserialises 8N1 RX frames into a holding
//   register with ready/overrun/frame-error flags.
//
// Ports
//   clk                    system clock
//   rst                    synchronous reset, active-high
//   data_mmio_addr         byte address from the core bus
//   data_mmio_wr_addr_val  single-cycle write strobe qualified by data_mmio_addr
//   data_mmio_wr_data      write data ([7:0] plus control bits)
//   data_mmio_rd_data      combinational read data for data_mmio_addr
//   rx                     asynchronous serial input, idle high
//   tx                     registered serial output, idle high
//
// Register window (offset from MMIO_BASE)
//   0x0 RX_CTRL  rd {ferr, overrun, ready}     wr [0] pop, [1] clr ovr, [2] clr ferr
//   0x4 RX_DATA  rd {24'b0, rx_byte}
//   0x8 TX_CTRL  rd {drop, idle, not_full}     wr [2] clr drop
//   0xC TX_DATA  wr push byte (dropped and flagged when full), rd 0

module risc_v_mike_mmio_uart #(
   parameter int unsigned CLKS_PER_BIT  = 434,
   parameter int unsigned TX_FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE     = 32'hFFFF0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_mmio_addr,
   input  logic        data_mmio_wr_addr_val,
   input  logic [31:0] data_mmio_wr_data,
   output logic [31:0] data_mmio_rd_data,
   input  logic        rx,
   output logic        tx
);

   localparam int unsigned PtrW = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

   // ---------------------------------------------------------------- decode
   logic       hit;
   logic [1:0] offset;
   logic       wr_en;
   logic       rx_pop, rx_ovr_clr, rx_ferr_clr, tx_drop_clr, tx_wr;

   assign hit    = (data_mmio_addr[31:4] == MMIO_BASE[31:4]);
   assign offset = data_mmio_addr[3:2];
   assign wr_en  = hit & data_mmio_wr_addr_val;

   assign rx_pop      = wr_en && (offset == 2'd0) && data_mmio_wr_data[0];
   assign rx_ovr_clr  = wr_en && (offset == 2'd0) && data_mmio_wr_data[1];
   assign rx_ferr_clr = wr_en && (offset == 2'd0) && data_mmio_wr_data[2];
   assign tx_drop_clr = wr_en && (offset == 2'd2) && data_mmio_wr_data[2];
   assign tx_wr       = wr_en && (offset == 2'd3);

   logic unused_bits;
   assign unused_bits = ^{data_mmio_addr[1:0], data_mmio_wr_data[31:8]};

   // ---------------------------------------------------------------- TX FIFO
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
   logic [PtrW:0] wr_ptr_q, rd_ptr_q;
   logic          fifo_empty, fifo_full;
   logic          fifo_push, fifo_pop, tx_drop_set;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

   // Full is judged before any same-cycle pop, so a write to a full FIFO drops.
   assign fifo_push   = tx_wr && !fifo_full;
   assign tx_drop_set = tx_wr && fifo_full;

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr_q[PtrW-1:0]] <= data_mmio_wr_data[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   tx_state_e       tx_state_q;
   logic [CntW-1:0] tx_cnt_q;
   logic [2:0]      tx_bit_q;
   logic [7:0]      tx_shift_q;
   logic            tx_q;
   logic            tx_drop_q;
   logic            tx_idle;

   // Pop from IDLE, or at the last cycle of STOP for gap-free back-to-back frames.
   assign fifo_pop = !fifo_empty &&
                     ((tx_state_q == TxIdle) ||
                      ((tx_state_q == TxStop) && (tx_cnt_q == BitLast)));

   assign tx_idle = fifo_empty && (tx_state_q == TxIdle);
   assign tx      = tx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         // Line level follows the state one cycle late, giving the push-to-fall
         // latency of two edges.
         unique case (tx_state_q)
            TxStart: tx_q <= 1'b0;
            TxData:  tx_q <= tx_shift_q[0];
            default: tx_q <= 1'b1;
         endcase

         unique case (tx_state_q)
            TxIdle: begin
               if (fifo_pop) begin
                  tx_shift_q <= fifo_mem[rd_ptr_q[PtrW-1:0]];
                  tx_cnt_q   <= '0;
                  tx_state_q <= TxStart;
               end
            end
            TxStart: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_state_q <= TxData;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TxData: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q   <= '0;
                  tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                  if (tx_bit_q == 3'd7) tx_state_q <= TxStop;
                  else                  tx_bit_q   <= tx_bit_q + 1'b1;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TxStop: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q <= '0;
                  if (fifo_pop) begin
                     tx_shift_q <= fifo_mem[rd_ptr_q[PtrW-1:0]];
                     tx_state_q <= TxStart;
                  end else begin
                     tx_state_q <= TxIdle;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   // Set wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_drop_q <= 1'b0;
      end else begin
         if (tx_drop_clr) tx_drop_q <= 1'b0;
         if (tx_drop_set) tx_drop_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- RX path
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e       rx_state_q;
   logic [CntW-1:0] rx_cnt_q;
   logic [2:0]      rx_bit_q;
   logic [7:0]      rx_shift_q;
   logic            rx_fall;
   logic            rx_stop_done, rx_commit, rx_ferr_set;

   // rx_s3_q only serves falling-edge detection on the synchronised line.
   assign rx_fall      = rx_s3_q & ~rx_s2_q;
   assign rx_stop_done = (rx_state_q == RxStop) && (rx_cnt_q == BitLast);
   assign rx_commit    = rx_stop_done & rx_s2_q;
   assign rx_ferr_set  = rx_stop_done & ~rx_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;

         unique case (rx_state_q)
            RxIdle: begin
               if (rx_fall) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RxStart;
               end
            end
            RxStart: begin
               // Mid-start sample; a high line here means the edge was a glitch.
               if (rx_cnt_q == HalfLast) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s2_q ? RxIdle : RxData;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RxData: begin
               if (rx_cnt_q == BitLast) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                  else                  rx_bit_q   <= rx_bit_q + 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RxStop: begin
               if (rx_cnt_q == BitLast) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RxIdle;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX flags
   logic       rx_ready_q, rx_ovr_q, rx_ferr_q;
   logic [7:0] rx_byte_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ready_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_byte_q  <= '0;
      end else begin
         // Clears first so a same-cycle set takes priority.
         if (rx_pop)      rx_ready_q <= 1'b0;
         if (rx_ovr_clr)  rx_ovr_q   <= 1'b0;
         if (rx_ferr_clr) rx_ferr_q  <= 1'b0;
         if (rx_commit) begin
            // A pop in the commit cycle frees the holding register for the new byte.
            if (!rx_ready_q || rx_pop) begin
               rx_byte_q  <= rx_shift_q;
               rx_ready_q <= 1'b1;
            end else begin
               rx_ovr_q <= 1'b1;
            end
         end
         if (rx_ferr_set) rx_ferr_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- read mux
   always_comb begin
      data_mmio_rd_data = '0;
      if (hit) begin
         case (offset)
            2'd0:    data_mmio_rd_data = {29'b0, rx_ferr_q, rx_ovr_q, rx_ready_q};
            2'd1:    data_mmio_rd_data = {24'b0, rx_byte_q};
            2'd2:    data_mmio_rd_data = {29'b0, tx_drop_q, tx_idle, !fifo_full};
            default: data_mmio_rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_risc_v_mike_mmio_uart.sv
// Directed bench for risc_v_mike_mmio_uart with CLKS_PER_BIT=4, depth 4.
module tb_risc_v_mike_mmio_uart;

   localparam int CPB = 4;
   localparam logic [31:0] RX_CTRL = 32'hFFFF0000;
   localparam logic [31:0] RX_DATA = 32'hFFFF0004;
   localparam logic [31:0] TX_CTRL = 32'hFFFF0008;
   localparam logic [31:0] TX_DATA = 32'hFFFF000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        wr_val = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        rx = 1'b1;
   logic        tx;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   risc_v_mike_mmio_uart #(
      .CLKS_PER_BIT (CPB),
      .TX_FIFO_DEPTH(4),
      .MMIO_BASE    (32'hFFFF0000)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .data_mmio_addr       (addr),
      .data_mmio_wr_addr_val(wr_val),
      .data_mmio_wr_data    (wr_data),
      .data_mmio_rd_data    (rd_data),
      .rx                   (rx),
      .tx                   (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ TX monitor
   logic [7:0] mon_bytes[$];
   logic       mon_stop[$];
   int         mon_start[$];

   initial begin
      logic [7:0] b;
      int         st;
      forever begin
         @(negedge clk);
         if (tx === 1'b0 && !rst) begin
            st = cyc;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            mon_bytes.push_back(b);
            mon_stop.push_back(tx);
            mon_start.push_back(st);
         end
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr    = a;
      wr_data = d;
      wr_val  = 1'b1;
      @(posedge clk);
   endtask

   task automatic bus_end();
      @(negedge clk);
      wr_val = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      wr_val = 1'b0;
      addr   = a;
      #1;
      check(name, rd_data, exp);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = f[i];
         repeat (CPB - 1) @(negedge clk);
      end
      if (!stop_bit) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic wait_tx_idle(input string name, input int limit);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < limit) begin
         @(negedge clk);
         addr = TX_CTRL;
         #1;
         done = (rd_data == 32'h3);
         n++;
      end
      check(name, {31'b0, done}, 32'h1);
   endtask

   task automatic check_frames(input string name, input logic [7:0] exp_b[5]);
      check({name, "_count"}, mon_bytes.size(), 5);
      if (mon_bytes.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'b0, mon_bytes[i]}, {24'b0, exp_b[i]});
            check($sformatf("%s_stop%0d", name, i), {31'b0, mon_stop[i]}, 32'h1);
            if (i > 0)
               check($sformatf("%s_gap%0d", name, i), mon_start[i] - mon_start[i-1], 10 * CPB);
         end
      end
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_tx;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [9:0] frame;
      logic [7:0] exp_b[5];
      logic [31:0] exp;

      vecs[0]  = '{"rst_rx_ctrl",   RX_CTRL,       1'b0, 32'h0,   32'h0, 1'b1};
      vecs[1]  = '{"rst_rx_data",   RX_DATA,       1'b0, 32'h0,   32'h0, 1'b1};
      vecs[2]  = '{"rst_tx_ctrl",   TX_CTRL,       1'b0, 32'h0,   32'h3, 1'b1};
      vecs[3]  = '{"rst_tx_data",   TX_DATA,       1'b0, 32'h0,   32'h0, 1'b1};
      vecs[4]  = '{"miss_0010",     32'hFFFF0010,  1'b0, 32'h0,   32'h0, 1'b1};
      vecs[5]  = '{"miss_low",      32'h00000008,  1'b0, 32'h0,   32'h0, 1'b1};
      vecs[6]  = '{"miss_wr_0010",  32'hFFFF0010,  1'b1, 32'hFF,  32'h0, 1'b1};
      vecs[7]  = '{"tx_ctrl_after", TX_CTRL,       1'b0, 32'h0,   32'h3, 1'b1};
      vecs[8]  = '{"wr_rx_data",    RX_DATA,       1'b1, 32'hFF,  32'h0, 1'b1};
      vecs[9]  = '{"wr_rx_ctrl",    RX_CTRL,       1'b1, 32'h7,   32'h0, 1'b1};
      vecs[10] = '{"miss_fffe",     32'hFFFE0008,  1'b0, 32'h0,   32'h0, 1'b1};
      vecs[11] = '{"byte_offs",     32'hFFFF000A,  1'b0, 32'h0,   32'h3, 1'b1};
      vecs[12] = '{"miss_wr_high",  32'hFFFF001C,  1'b1, 32'h55,  32'h0, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Register window after reset and out-of-window accesses.
      foreach (vecs[i]) begin
         @(negedge clk);
         addr    = vecs[i].addr;
         wr_data = vecs[i].data;
         wr_val  = vecs[i].wr;
         @(posedge clk);
         @(negedge clk);
         wr_val = 1'b0;
         #1;
         check(vecs[i].name, rd_data, vecs[i].exp_rd);
         check({vecs[i].name, "_tx"}, {31'b0, tx}, {31'b0, vecs[i].exp_tx});
      end
      check_reg("tx_ctrl_no_push", TX_CTRL, 32'h3);

      // Single byte 0x55: exact line waveform and idle timing.
      frame = {1'b1, 8'h55, 1'b0};
      bus_write(TX_DATA, 32'h155);
      @(negedge clk);
      wr_val = 1'b0;
      addr   = TX_CTRL;
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         #1;
         if (k < 2 || k > 41) exp = 32'h1;
         else                 exp = {31'b0, frame[(k - 2) / CPB]};
         check($sformatf("tx55_k%0d", k), {31'b0, tx}, exp);
         if (k == 40) check("tx_idle_k40", rd_data, 32'h1);
         if (k == 41) check("tx_idle_k41", rd_data, 32'h3);
      end
      mon_bytes.delete();
      mon_stop.delete();
      mon_start.delete();

      // Five back-to-back writes: first pop frees a slot, all accepted, no gaps.
      for (int i = 0; i < 5; i++) bus_write(TX_DATA, 32'(i + 1));
      bus_end();
      wait_tx_idle("b2b_idle", 400);
      exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_frames("b2b", exp_b);
      check_reg("b2b_no_drop", TX_CTRL, 32'h3);
      mon_bytes.delete();
      mon_stop.delete();
      mon_start.delete();

      // FSM busy with 0xAA; four fill the FIFO, fifth is dropped.
      bus_write(TX_DATA, 32'hAA);
      for (int i = 0; i < 5; i++) bus_write(TX_DATA, 32'hB1 + 32'(i));
      bus_end();
      check_reg("drop_flag", TX_CTRL, 32'h4);
      bus_write(TX_CTRL, 32'h4);
      bus_end();
      check_reg("drop_clear", TX_CTRL, 32'h0);
      wait_tx_idle("drop_idle", 400);
      exp_b = '{8'hAA, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      check_frames("drop", exp_b);

      // RX: first byte, then overrun on second without pop.
      send_rx(8'hA5, 1'b1);
      repeat (2) @(negedge clk);
      check_reg("rx1_ctrl", RX_CTRL, 32'h1);
      check_reg("rx1_data", RX_DATA, 32'hA5);
      send_rx(8'h3C, 1'b1);
      repeat (2) @(negedge clk);
      check_reg("rx2_ctrl", RX_CTRL, 32'h3);
      check_reg("rx2_data", RX_DATA, 32'hA5);
      bus_write(RX_CTRL, 32'h3);
      bus_end();
      check_reg("rx_clear", RX_CTRL, 32'h0);

      // Stop bit low: byte discarded, frame error flagged.
      send_rx(8'h5A, 1'b0);
      repeat (2) @(negedge clk);
      check_reg("ferr_ctrl", RX_CTRL, 32'h4);
      check_reg("ferr_data", RX_DATA, 32'hA5);
      bus_write(RX_CTRL, 32'h4);
      bus_end();
      check_reg("ferr_clear", RX_CTRL, 32'h0);

      // One-cycle low glitch is rejected at the mid-start sample.
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check_reg("glitch_ctrl", RX_CTRL, 32'h0);
      check_reg("glitch_data", RX_DATA, 32'hA5);

      // Pop lands in the exact commit cycle of 0x77.
      send_rx(8'h11, 1'b1);
      repeat (2) @(negedge clk);
      check_reg("pre_pop_data", RX_DATA, 32'h11);
      fork
         send_rx(8'h77, 1'b1);
         begin
            repeat (41) @(negedge clk);
            addr    = RX_CTRL;
            wr_data = 32'h1;
            wr_val  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            wr_val = 1'b0;
         end
      join
      check_reg("pop_commit_data", RX_DATA, 32'h77);
      check_reg("pop_commit_ctrl", RX_CTRL, 32'h1);

      // Overrun set in the same cycle as an overrun clear: set wins.
      fork
         send_rx(8'h99, 1'b1);
         begin
            repeat (41) @(negedge clk);
            addr    = RX_CTRL;
            wr_data = 32'h2;
            wr_val  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            wr_val = 1'b0;
         end
      join
      check_reg("ovr_prec_ctrl", RX_CTRL, 32'h3);
      check_reg("ovr_prec_data", RX_DATA, 32'h77);
      bus_write(RX_CTRL, 32'h3);
      bus_end();

      // Reset mid-TX-frame (data bits low) and mid-RX-frame.
      bus_write(TX_DATA, 32'h00);
      bus_end();
      fork
         send_rx(8'hFF, 1'b1);
      join_none
      repeat (16) @(negedge clk);
      #1;
      check("pre_rst_tx_low", {31'b0, tx}, 32'h0);
      @(negedge clk);
      rst  = 1'b1;
      addr = RX_CTRL;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_tx", {31'b0, tx}, 32'h1);
      check("rst_rx_ctrl_now", rd_data, 32'h0);
      addr = TX_CTRL;
      #1;
      check("rst_tx_ctrl_now", rd_data, 32'h3);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check_reg("post_rst_rx_ctrl", RX_CTRL, 32'h0);
      check_reg("post_rst_tx_ctrl", TX_CTRL, 32'h3);
      check("post_rst_tx", {31'b0, tx}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/risc_v_mike_mmio_uart.md
Name: risc_v_mike_mmio_uart

Overview:
- Memory-mapped UART responder at the MMIO end of the core's data bus.
- The core initiates MMIO writes through an address, a write-valid and write-data; it samples read data combinationally into its memory data register.
- This block decodes a 4-word register window, buffers TX bytes in a small FIFO, serialises them as 8N1, and deserialises 8N1 RX frames into a holding register with status flags.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (>=4).
TX_FIFO_DEPTH, 4, TX FIFO entries; power of two, >=2.
MMIO_BASE, 32'hFFFF0000, base of the register window; bits [3:0] are zero.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
data_mmio_addr  input  32  byte address from the core bus
data_mmio_wr_addr_val  input  1  write strobe, single-cycle, qualified by data_mmio_addr
data_mmio_wr_data  input  32  write data; only [7:0] and the listed control bits are used
data_mmio_rd_data  output  32  combinational read data for data_mmio_addr
rx  input  1  asynchronous serial input, idle high
tx  output  1  registered serial output, idle high

Behaviour:
- Decode: hit when data_mmio_addr[31:4] == MMIO_BASE[31:4]. Offset is addr[3:2]. No hit gives rd_data = 0, and writes are ignored. Reads have no side effects, because the bus reads every cycle.
- Offset 0x0 RX_CTRL:
  - Read: [0] rx_ready, [1] rx_overrun, [2] rx_frame_err, rest 0.
  - Write: [0]=1 clears rx_ready (pop); [1]=1 clears overrun; [2]=1 clears frame_err.
- Offset 0x4 RX_DATA: read {24'b0, rx_byte}. Writes are ignored.
- Offset 0x8 TX_CTRL:
  - Read: [0] tx_ready (FIFO not full), [1] tx_idle (FIFO empty and TX FSM in IDLE), [2] tx_drop, rest 0.
  - Write: [2]=1 clears tx_drop.
- Offset 0xC TX_DATA:
  - Write pushes wr_data[7:0] when not full.
  - Write while full drops the byte and sets tx_drop. Full is evaluated before any same-cycle pop.
  - Read returns 0.
- Reset values:
  - tx=1; FIFO empty; all flags 0; rx_byte=0; both FSMs IDLE; counters 0.
  - rd_data follows decode: RX_CTRL reads 0, TX_CTRL reads 32'h3.
  - Reset mid-frame aborts immediately: tx=1 on the next cycle and the partial RX frame is discarded.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop the head into the shifter and go to START.
  - A push at edge N makes tx fall at edge N+2.
  - Each state holds for CLKS_PER_BIT cycles. START drives 0; DATA drives 8 bits LSB-first (bit index 0..7); STOP drives 1.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- RX path: rx passes through a 2-FF synchroniser (2-cycle latency). RX FSM (IDLE, START, DATA, STOP):
  - IDLE: falling synchronised rx goes to START.
  - START: after CLKS_PER_BIT/2 cycles, sample. If 1, it was a glitch; return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB-first.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE on the same cycle.
    - Sample 1: commit.
    - Sample 0: discard the byte and set rx_frame_err.
- Commit rules:
  - rx_ready=0: load rx_byte and set rx_ready.
  - rx_ready=1: keep the old byte and set rx_overrun, unless a pop arrives the same cycle.
  - Commit plus pop in the same cycle: load the new byte, rx_ready stays 1, no overrun.
- Flag precedence: a set in the same cycle as a clear wins for overrun, frame_err and tx_drop.
- FIFO pointers are log2(TX_FIFO_DEPTH)+1 bits wide with wrap. Push and pop in the same cycle when not full keeps the count unchanged.

Test Plan:
- CLKS_PER_BIT=4. Write 0xFFFF000C = 0x155 -> tx low at +2 cycles; pattern 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit (byte 0x55); tx_idle=1 after 40 cycles.
- Write 5 bytes 0x01..0x05 back-to-back, depth 4:
  - The first byte is popped before the fifth write, so all 5 are accepted.
  - Frames are contiguous with no idle gap.
  - Repeat with the FSM busy and 5 writes while full -> 5th dropped, TX_CTRL reads 0x4|flags; write 0x4 to TX_CTRL clears it.
- Drive RX frame 0xA5 -> within 2+40 cycles RX_CTRL=0x1, RX_DATA=0xA5. A second frame 0x3C without pop gives RX_CTRL=0x3 and RX_DATA still 0xA5. Write 0x3 to RX_CTRL gives 0x0.
- RX frame with stop bit 0 -> RX_CTRL=0x4, rx_ready=0. A 1-cycle low glitch on rx -> no state change.
- Pop written in the exact commit cycle of a second byte 0x77 -> RX_DATA=0x77, RX_CTRL=0x1.
- Assert rst mid-TX-frame and mid-RX-frame -> next cycle tx=1, RX_CTRL=0, TX_CTRL=0x3. Access to 0xFFFF0010 -> rd_data=0 and no state change.
